ft600_tx_stream: RTL and testbench

- Parametrised FT600/FT601 245-synchronous write engine; successor to the fixed 8-word pattern transmitter.
- Accepts a valid/ready word stream into an internal FIFO and drives the FTDI write bus with correct TXE_N back-pressure: no word is lost or duplicated when TXE_N deasserts mid-burst.
- Built-in incrementing-pattern mode for link bring-up.
- Sits between user data path and the top-level pad/tristate wrapper; write-only (read side held idle).

---
 rtl/ft600_tx_stream.sv | 76 +++++++
 tb/tb_ft600_tx_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_tx_stream.sv
// ft600_tx_stream: FT600/FT601 245-sync write engine with input FIFO, TXE_N back-pressure and pattern mode
module ft600_tx_stream #(
    parameter int DATA_W     = 16,
    parameter int BE_W       = DATA_W / 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              ftdi_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [BE_W-1:0]   s_tkeep,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              pattern_en,
    input  logic              ftdi_txe_n,
    output logic              ftdi_wr_n,
    output logic [DATA_W-1:0] ftdi_data_o,
    output logic [BE_W-1:0]   ftdi_be_o,
    output logic              ftdi_data_oe,
    output logic              ftdi_oe_n,
    output logic              ftdi_rd_n,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [31:0]       words_sent
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [BE_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_W-1:0]      pat_cnt;
    logic [LVL_W-1:0]       lvl_nxt;
    logic                   out_valid, nxt_valid, accept, load, push, pop, fifo_ne;
    assign ftdi_oe_n = 1'b1;
    assign ftdi_rd_n = 1'b1;
    always_comb begin
        accept    = !ftdi_wr_n && !ftdi_txe_n;
        load      = !out_valid || accept;
        fifo_ne   = fifo_level != '0;
        push      = s_tvalid && s_tready;
        pop       = load && !pattern_en && fifo_ne;
        nxt_valid = load ? (pattern_en || fifo_ne) : out_valid;
        lvl_nxt   = fifo_level + LVL_W'(push) - LVL_W'(pop);
    end
    always_ff @(posedge ftdi_clk)
        if (push) mem[wr_ptr] <= {s_tkeep, s_tdata};
    // the output stage only reloads once its word is gone, so a word refused by TXE_N is re-presented as is
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            s_tready     <= 1'b0;
            ftdi_data_oe <= 1'b0;
            out_valid    <= 1'b0;
            ftdi_wr_n    <= 1'b1;
            ftdi_data_o  <= '0;
            ftdi_be_o    <= '0;
            pat_cnt      <= '0;
            words_sent   <= '0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            fifo_level   <= lvl_nxt;
            s_tready     <= lvl_nxt < LVL_W'(FIFO_DEPTH);
            ftdi_data_oe <= 1'b1;
            out_valid    <= nxt_valid;
            ftdi_wr_n    <= !(nxt_valid && !ftdi_txe_n);
            if (accept) words_sent <= words_sent + 32'd1;
            if (load && pattern_en) begin
                ftdi_data_o <= pat_cnt;
                ftdi_be_o   <= '1;
                pat_cnt     <= pat_cnt + DATA_W'(1);
            end else if (pop) begin
                {ftdi_be_o, ftdi_data_o} <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_ft600_tx_stream.sv
// tb_ft600_tx_stream: randomized bench with an in-order word scoreboard for ft600_tx_stream
module tb_ft600_tx_stream;
    logic        ftdi_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_tdata = '0;
    logic [1:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        pattern_en = 1'b0;
    logic        ftdi_txe_n = 1'b1;
    logic        ftdi_wr_n;
    logic [15:0] ftdi_data_o;
    logic [1:0]  ftdi_be_o;
    logic        ftdi_data_oe, ftdi_oe_n, ftdi_rd_n;
    logic [4:0]  fifo_level;
    logic [31:0] words_sent;
    int n_chk = 0, n_pass = 0;
    int acc = 0, tot_push = 0, pat_acc = 0, run = 0, max_run = 0;
    logic        pat_mode = 1'b0;
    logic [15:0] pcnt = '0;
    logic [17:0] q[$];
    ft600_tx_stream dut (
        .ftdi_clk(ftdi_clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .pattern_en(pattern_en),
        .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_data_o(ftdi_data_o),
        .ftdi_be_o(ftdi_be_o), .ftdi_data_oe(ftdi_data_oe), .ftdi_oe_n(ftdi_oe_n),
        .ftdi_rd_n(ftdi_rd_n), .fifo_level(fifo_level), .words_sent(words_sent)
    );
    always #5 ftdi_clk = ~ftdi_clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge ftdi_clk);
        #1;
    endtask
    task automatic push(input logic [15:0] d, input logic [1:0] k);
        int t = 0;
        s_tdata = d;
        s_tkeep = k;
        s_tvalid = 1'b1;
        while (!s_tready && t < 200) begin
            tick(1);
            t++;
        end
        if (!s_tready) check("push_timeout", 0, 1);
        tick(1);
        s_tvalid = 1'b0;
    endtask
    task automatic wait_idle();
        int t = 0;
        while (!(fifo_level == 0 && ftdi_wr_n && q.size() == 0) && t < 500) begin
            tick(1);
            t++;
        end
        if (t >= 500) check("idle_timeout", 0, 1);
        tick(2);
    endtask
    // reference: every handshaken word must come out once, in order, with its own keep mask
    always @(negedge ftdi_clk) begin
        logic [17:0] e;
        if (!rst_n) begin
            q.delete();
            pcnt = '0;
            run = 0;
        end else begin
            if (s_tvalid && s_tready) begin
                q.push_back({s_tkeep, s_tdata});
                tot_push++;
            end
            if (!ftdi_wr_n && !ftdi_txe_n) begin
                acc++;
                if (pat_mode) begin
                    check("pat_data", ftdi_data_o, pcnt);
                    check("pat_be", ftdi_be_o, 2'b11);
                    pcnt = pcnt + 16'd1;
                    pat_acc++;
                end else if (q.size() == 0) begin
                    check("unexpected_word", ftdi_data_o, 64'hdead_beef_0000);
                end else begin
                    e = q.pop_front();
                    check("data", ftdi_data_o, e[15:0]);
                    check("be", ftdi_be_o, e[17:16]);
                end
            end
            run = !ftdi_wr_n ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end
    initial begin
        logic [15:0] w[8];
        int base, n, wb;
        tick(3);
        check("rst_wr_n", ftdi_wr_n, 1);
        check("rst_data", ftdi_data_o, 0);
        check("rst_be", ftdi_be_o, 0);
        check("rst_oe", ftdi_data_oe, 0);
        check("rst_tready", s_tready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_words", words_sent, 0);
        check("oe_n", ftdi_oe_n, 1);
        check("rd_n", ftdi_rd_n, 1);
        rst_n = 1'b1;
        tick(1);
        check("oe_after_rst", ftdi_data_oe, 1);
        check("tready_after_rst", s_tready, 1);
        ftdi_txe_n = 1'b0;
        max_run = 0;
        push(16'h3130, 2'b11);
        push(16'h3332, 2'b11);
        push(16'h3534, 2'b11);
        wait_idle();
        check("t1_run", max_run, 3);
        check("t1_words", words_sent, 3);
        check("t1_wr_n", ftdi_wr_n, 1);
        check("t1_level", fifo_level, 0);
        foreach (w[i]) w[i] = 16'($urandom);
        base = acc;
        wb = words_sent;
        fork
            foreach (w[i]) push(w[i], 2'b11);
            begin
                int t = 0;
                while (!(!ftdi_wr_n && acc == base + 3) && t < 100) begin
                    tick(1);
                    t++;
                end
                check("t2_seen_w4", acc, base + 3);
                ftdi_txe_n = 1'b1;
                tick(1);
                check("t2_hold_wr_n", ftdi_wr_n, 1);
                check("t2_hold_data", ftdi_data_o, w[3]);
                tick(4);
                ftdi_txe_n = 1'b0;
                tick(1);
                check("t2_repr_wr_n", ftdi_wr_n, 0);
                check("t2_repr_data", ftdi_data_o, w[3]);
            end
        join
        wait_idle();
        check("t2_words", words_sent - wb, 8);
        check("t2_acc", acc - base, 8);
        ftdi_txe_n = 1'b1;
        wb = words_sent;
        n = 0;
        s_tvalid = 1'b1;
        s_tkeep = 2'b11;
        for (int t = 0; t < 40 && s_tready; t++) begin
            s_tdata = 16'($urandom);
            n++;
            tick(1);
        end
        check("t3_pushes", n, 17);
        check("t3_level", fifo_level, 16);
        check("t3_tready", s_tready, 0);
        tick(3);
        check("t3_level_held", fifo_level, 16);
        check("t3_wr_n_blocked", ftdi_wr_n, 1);
        s_tvalid = 1'b0;
        ftdi_txe_n = 1'b0;
        tick(1);
        check("t3_tready_pre_pop", s_tready, 0);
        tick(1);
        check("t3_tready_post_pop", s_tready, 1);
        check("t3_level_post_pop", fifo_level, 15);
        wait_idle();
        check("t3_words", words_sent - wb, 17);
        push(16'haaaa, 2'b11);
        push(16'hbbbb, 2'b11);
        push(16'hcccc, 2'b01);
        wait_idle();
        check("keep_hold_be", ftdi_be_o, 2'b01);
        check("keep_hold_data", ftdi_data_o, 16'hcccc);
        for (int t = 0; t < 400; t++) begin
            ftdi_txe_n = ($urandom % 4) == 0;
            s_tvalid = $urandom % 2;
            s_tdata = 16'($urandom);
            s_tkeep = 2'($urandom_range(1, 3));
            tick(1);
        end
        s_tvalid = 1'b0;
        ftdi_txe_n = 1'b0;
        wait_idle();
        check("rand_words", words_sent, tot_push);
        check("rand_queue", q.size(), 0);
        wb = words_sent;
        pat_mode = 1'b1;
        pattern_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            ftdi_txe_n = (t == 8);
            tick(1);
            if (pat_acc >= 20) break;
        end
        ftdi_txe_n = 1'b1;
        tick(2);
        check("pat_count", pat_acc, 20);
        check("pat_words", words_sent - wb, 20);
        pattern_en = 1'b0;
        for (int i = 0; i < 4; i++) push(16'($urandom), 2'b11);
        check("rst_mid_level", fifo_level, 4);
        ftdi_txe_n = 1'b0;
        tick(1);
        check("rst_mid_wr_n", ftdi_wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        pat_mode = 1'b0;
        check("async_wr_n", ftdi_wr_n, 1);
        check("async_data", ftdi_data_o, 0);
        check("async_be", ftdi_be_o, 0);
        check("async_oe", ftdi_data_oe, 0);
        check("async_tready", s_tready, 0);
        check("async_level", fifo_level, 0);
        check("async_words", words_sent, 0);
        tick(2);
        rst_n = 1'b1;
        base = acc;
        tick(10);
        check("post_rst_acc", acc - base, 0);
        check("post_rst_words", words_sent, 0);
        check("post_rst_wr_n", ftdi_wr_n, 1);
        check("post_rst_level", fifo_level, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
